// File: rtl/fft_frame_loader.sv
// Serial-to-parallel loader: packs N_POINTS samples per frame into a flat word,
// double-buffered so one bank fills while the other is held for the consumer.
module fft_frame_loader #(
   parameter int N_POINTS = 64,
   parameter int LOG2_N   = 6,
   parameter int S_WIDTH  = 16
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [S_WIDTH-1:0]           in_sample,
   input  logic                         in_valid,
   input  logic                         in_last,
   output logic                         in_ready,
   output logic [S_WIDTH*N_POINTS-1:0]  frame_out,
   output logic                         frame_valid,
   input  logic                         frame_ready,
   output logic                         err_abort,
   output logic [LOG2_N-1:0]            wr_idx
);

   // Handshake: a sample moves when in_valid && in_ready at a rising edge; a frame
   // moves when frame_valid && frame_ready. in_ready depends on registers only.
   localparam logic [LOG2_N-1:0] LAST_IDX = LOG2_N'(N_POINTS - 1);

   logic [S_WIDTH-1:0] bank_q [0:1][0:N_POINTS-1];
   logic [1:0]         full_q, full_d;
   logic               wr_bank_q, wr_bank_d;
   logic               rd_bank_q, rd_bank_d;
   logic [LOG2_N-1:0]  wr_idx_q, wr_idx_d;
   logic               err_abort_q, err_abort_d;

   logic accept, pop, last_slot, store;

   assign in_ready    = !full_q[wr_bank_q];
   assign frame_valid = full_q[rd_bank_q];
   assign err_abort   = err_abort_q;
   assign wr_idx      = wr_idx_q;

   assign accept    = in_valid && in_ready;
   assign pop       = frame_valid && frame_ready;
   assign last_slot = (wr_idx_q == LAST_IDX);
   // in_last at the final slot is ignored; anywhere else it aborts the frame.
   assign store     = accept && (last_slot || !in_last);

   for (genvar g = 0; g < N_POINTS; g++) begin : g_pack
      assign frame_out[g*S_WIDTH +: S_WIDTH] = bank_q[rd_bank_q][g];
   end

   always_comb begin
      full_d      = full_q;
      wr_bank_d   = wr_bank_q;
      rd_bank_d   = rd_bank_q;
      wr_idx_d    = wr_idx_q;
      err_abort_d = 1'b0;
      if (accept) begin
         if (last_slot) begin
            full_d[wr_bank_q] = 1'b1;
            wr_bank_d         = !wr_bank_q;
            wr_idx_d          = '0;
         end else if (in_last) begin
            wr_idx_d    = '0;
            err_abort_d = 1'b1;
         end else begin
            wr_idx_d = wr_idx_q + 1'b1;
         end
      end
      // A pop always targets the other bank from a completing accept.
      if (pop) begin
         full_d[rd_bank_q] = 1'b0;
         rd_bank_d         = !rd_bank_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         full_q      <= 2'b00;
         wr_bank_q   <= 1'b0;
         rd_bank_q   <= 1'b0;
         wr_idx_q    <= '0;
         err_abort_q <= 1'b0;
      end else begin
         full_q      <= full_d;
         wr_bank_q   <= wr_bank_d;
         rd_bank_q   <= rd_bank_d;
         wr_idx_q    <= wr_idx_d;
         err_abort_q <= err_abort_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int b = 0; b < 2; b++) begin
            for (int i = 0; i < N_POINTS; i++) begin
               bank_q[b][i] <= '0;
            end
         end
      end else if (store) begin
         bank_q[wr_bank_q][wr_idx_q] <= in_sample;
      end
   end

endmodule

// File: tb/tb_fft_frame_loader.sv
// Directed bench for fft_frame_loader: fill, hold, abort, overlap, reset and gapped input.
module tb_fft_frame_loader;

   localparam int N  = 64;
   localparam int SW = 16;
   localparam int FW = N * SW;

   logic          clk = 1'b0;
   logic          rst;
   logic [SW-1:0] in_sample;
   logic          in_valid;
   logic          in_last;
   logic          in_ready;
   logic [FW-1:0] frame_out;
   logic          frame_valid;
   logic          frame_ready;
   logic          err_abort;
   logic [5:0]    wr_idx;

   int checks   = 0;
   int failures = 0;

   logic [SW-1:0] exp_q[$];
   logic [FW-1:0] exp_a;
   logic [FW-1:0] exp_b;

   fft_frame_loader #(.N_POINTS(N), .LOG2_N(6), .S_WIDTH(SW)) dut (
      .clk(clk), .rst(rst), .in_sample(in_sample), .in_valid(in_valid),
      .in_last(in_last), .in_ready(in_ready), .frame_out(frame_out),
      .frame_valid(frame_valid), .frame_ready(frame_ready),
      .err_abort(err_abort), .wr_idx(wr_idx)
   );

   always #5 clk = ~clk;

   // ---------------- driver tasks (all start and end on a negedge) ----------
   task automatic apply_reset();
      rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_sample = '0; frame_ready = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic send(input logic [SW-1:0] s, input logic last);
      int waited;
      waited = 0;
      in_valid = 1'b1; in_sample = s; in_last = last;
      while (!in_ready && waited < 500) begin
         @(negedge clk);
         waited++;
      end
      if (!in_ready) begin
         checks++; failures++;
         $display("FAIL send_timeout sample=%h in_ready stuck at %b, required 1", s, in_ready);
      end
      @(negedge clk);
      in_valid = 1'b0; in_last = 1'b0;
   endtask

   // ---------------- scenarios ----------------------------------------------
   task automatic test_reset();
      apply_reset();
      checks++;
      if (in_ready !== 1'b1 || frame_valid !== 1'b0 || err_abort !== 1'b0 || wr_idx !== 6'd0) begin
         failures++;
         $display("FAIL reset_ctrl got rdy=%b fv=%b err=%b idx=%0d, required 1 0 0 0",
                  in_ready, frame_valid, err_abort, wr_idx);
      end
      checks++;
      if (frame_out !== '0) begin
         failures++; $display("FAIL reset_frame got nonzero frame_out, required 0");
      end
   endtask

   task automatic test_single_frame();
      apply_reset();
      frame_ready = 1'b1;
      for (int i = 0; i < N - 1; i++) send(SW'(i), 1'b0);
      checks++;
      if (frame_valid !== 1'b0) begin
         failures++; $display("FAIL single_early_valid got %b required 0", frame_valid);
      end
      send(SW'(N - 1), 1'b1);
      checks++;
      if (frame_valid !== 1'b1 || wr_idx !== 6'd0) begin
         failures++;
         $display("FAIL single_valid got fv=%b idx=%0d required 1 0", frame_valid, wr_idx);
      end
      for (int i = 0; i < N; i++) exp_a[i*SW +: SW] = SW'(i);
      checks++;
      if (frame_out !== exp_a) begin
         failures++;
         $display("FAIL single_data lane0=%h lane63=%h required 0000 003f",
                  frame_out[15:0], frame_out[FW-1 -: SW]);
      end
      @(negedge clk);
      frame_ready = 1'b0;
      checks++;
      if (frame_valid !== 1'b0) begin
         failures++; $display("FAIL single_pop got fv=%b required 0", frame_valid);
      end
   endtask

   task automatic test_back_to_back();
      int bad;
      apply_reset();
      for (int i = 0; i < N; i++) begin
         exp_a[i*SW +: SW] = SW'(i);
         exp_b[i*SW +: SW] = SW'(i + N);
      end
      for (int i = 0; i < 2 * N; i++) send(SW'(i), 1'b0);
      checks++;
      if (in_ready !== 1'b0 || frame_valid !== 1'b1) begin
         failures++;
         $display("FAIL b2b_full got rdy=%b fv=%b required 0 1", in_ready, frame_valid);
      end
      in_valid = 1'b1; in_sample = SW'(128); in_last = 1'b0;
      bad = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (frame_out !== exp_a || wr_idx !== 6'd0 || in_ready !== 1'b0) bad++;
      end
      checks++;
      if (bad != 0) begin
         failures++; $display("FAIL b2b_hold unstable cycles=%0d required 0", bad);
      end
      frame_ready = 1'b1;
      @(negedge clk);
      frame_ready = 1'b0;
      checks++;
      if (frame_out !== exp_b || in_ready !== 1'b1 || frame_valid !== 1'b1) begin
         failures++;
         $display("FAIL b2b_pop lane0=%h rdy=%b fv=%b required 0040 1 1",
                  frame_out[15:0], in_ready, frame_valid);
      end
      checks++;
      if (wr_idx !== 6'd0) begin
         failures++; $display("FAIL b2b_no_early_accept idx=%0d required 0", wr_idx);
      end
      @(negedge clk);
      in_valid = 1'b0;
      checks++;
      if (wr_idx !== 6'd1) begin
         failures++; $display("FAIL b2b_accept128 idx=%0d required 1", wr_idx);
      end
   endtask

   task automatic test_early_last();
      apply_reset();
      for (int i = 0; i < 10; i++) send(SW'(16'h0100 + i), 1'b0);
      checks++;
      if (wr_idx !== 6'd10) begin
         failures++; $display("FAIL abort_pre idx=%0d required 10", wr_idx);
      end
      send(SW'(16'h010a), 1'b1);
      checks++;
      if (err_abort !== 1'b1 || wr_idx !== 6'd0 || frame_valid !== 1'b0) begin
         failures++;
         $display("FAIL abort_pulse err=%b idx=%0d fv=%b required 1 0 0", err_abort, wr_idx, frame_valid);
      end
      @(negedge clk);
      checks++;
      if (err_abort !== 1'b0) begin
         failures++; $display("FAIL abort_width err=%b required 0", err_abort);
      end
      for (int i = 0; i < N; i++) send(16'hA5A5, (i == N - 1));
      exp_a = {N{16'hA5A5}};
      checks++;
      if (frame_valid !== 1'b1 || frame_out !== exp_a || err_abort !== 1'b0) begin
         failures++;
         $display("FAIL abort_refill fv=%b lane0=%h lane10=%h err=%b required 1 a5a5 a5a5 0",
                  frame_valid, frame_out[15:0], frame_out[175:160], err_abort);
      end
   endtask

   task automatic test_pop_overlap();
      apply_reset();
      for (int i = 0; i < N; i++) begin
         exp_a[i*SW +: SW] = SW'(16'h1000 + i);
         exp_b[i*SW +: SW] = SW'(16'h2000 + i);
      end
      for (int i = 0; i < N; i++) send(SW'(16'h1000 + i), 1'b0);
      for (int i = 0; i < N - 1; i++) send(SW'(16'h2000 + i), 1'b0);
      checks++;
      if (frame_out !== exp_a || frame_valid !== 1'b1 || in_ready !== 1'b1) begin
         failures++;
         $display("FAIL overlap_pre lane0=%h fv=%b rdy=%b required 1000 1 1",
                  frame_out[15:0], frame_valid, in_ready);
      end
      frame_ready = 1'b1;
      send(SW'(16'h2000 + N - 1), 1'b1);
      frame_ready = 1'b0;
      checks++;
      if (frame_valid !== 1'b1 || frame_out !== exp_b || in_ready !== 1'b1) begin
         failures++;
         $display("FAIL overlap_post fv=%b lane0=%h lane63=%h rdy=%b required 1 2000 203f 1",
                  frame_valid, frame_out[15:0], frame_out[FW-1 -: SW], in_ready);
      end
   endtask

   task automatic test_reset_midframe();
      apply_reset();
      for (int i = 0; i < N; i++) send(SW'(16'h5000 + i), 1'b0);
      for (int i = 0; i < 30; i++) send(SW'(16'h6000 + i), 1'b0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checks++;
      if (frame_valid !== 1'b0 || in_ready !== 1'b1 || wr_idx !== 6'd0 || frame_out !== '0) begin
         failures++;
         $display("FAIL midreset fv=%b rdy=%b idx=%0d lane0=%h required 0 1 0 0000",
                  frame_valid, in_ready, wr_idx, frame_out[15:0]);
      end
      for (int i = 0; i < N; i++) begin
         exp_a[i*SW +: SW] = SW'(16'h3000 + 3 * i);
         send(SW'(16'h3000 + 3 * i), 1'b0);
      end
      checks++;
      if (frame_valid !== 1'b1 || frame_out !== exp_a) begin
         failures++;
         $display("FAIL midreset_reload fv=%b lane1=%h required 1 3003", frame_valid, frame_out[31:16]);
      end
   endtask

   task automatic test_random_gaps();
      int gap_bad, order_bad, spins;
      logic [SW-1:0] val;
      logic [5:0] idx_before;
      logic took;
      apply_reset();
      gap_bad = 0; order_bad = 0;
      exp_q.delete();
      for (int i = 0; i < N; i++) begin
         val = SW'($urandom_range(0, 16'hFFFF));
         exp_q.push_back(val);
         in_sample = val;
         took = 1'b0; spins = 0;
         while (!took && spins < 1000) begin
            in_valid = 1'($urandom_range(0, 1));
            took = in_valid;
            idx_before = wr_idx;
            @(negedge clk);
            if (!took && wr_idx !== idx_before) gap_bad++;
            spins++;
         end
         if (!took) gap_bad++;
         if (wr_idx !== 6'((i + 1) % N)) gap_bad++;
      end
      in_valid = 1'b0;
      checks++;
      if (gap_bad != 0) begin
         failures++; $display("FAIL gaps_idx bad_steps=%0d required 0", gap_bad);
      end
      for (int i = 0; i < N; i++) begin
         val = exp_q.pop_front();
         if (frame_out[i*SW +: SW] !== val) order_bad++;
      end
      checks++;
      if (order_bad != 0 || frame_valid !== 1'b1) begin
         failures++;
         $display("FAIL gaps_data wrong_lanes=%0d fv=%b required 0 1", order_bad, frame_valid);
      end
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_sample = '0; frame_ready = 1'b0;
      @(negedge clk);
      test_reset();
      test_single_frame();
      test_back_to_back();
      test_early_last();
      test_pop_overlap();
      test_reset_midframe();
      test_random_gaps();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/fft_frame_loader.md
# fft_frame_loader

Serial-to-parallel front end for the 64-point FFT datapath. It accepts one 16-bit sample per cycle over a valid/ready stream and packs 64 consecutive samples into a flat frame word. It double-buffers frames so one frame can be filled while the previous one is held. Its frame output feeds the `input_sig` port of `InputSignalSorter` directly, using the same packing: sample i occupies bits [16*i+15 -: 16].

## Interface
- `N_POINTS`, 64, samples per frame; power of two.
- `LOG2_N`, 6, log2(N_POINTS); width of the sample index.
- `S_WIDTH`, 16, bits per sample.
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_sample`  in  S_WIDTH  incoming sample.
- `in_valid`  in  1  `in_sample` is valid this cycle.
- `in_last`  in  1  marks the final sample of a frame; qualified by `in_valid`.
- `in_ready`  out  1  loader can accept a sample this cycle.
- `frame_out`  out  S_WIDTH*N_POINTS  packed frame presented to the sorter.
- `frame_valid`  out  1  `frame_out` holds a complete frame.
- `frame_ready`  in  1  downstream consumes the frame when asserted with `frame_valid`.
- `err_abort`  out  1  one-cycle pulse: a frame was aborted by an early `in_last`.
- `wr_idx`  out  LOG2_N  index the next accepted sample will occupy (debug/observability).

## Operation
- Storage: two banks (0, 1), each N_POINTS x S_WIDTH, with a `full[1:0]` flag per bank.
- Pointers: `wr_bank`, `rd_bank` (1 bit each) and `wr_idx` (LOG2_N bits).
- `in_ready = !full[wr_bank]`, decoded combinationally from registers only. There is no combinational path from `frame_ready`.
- Accept occurs when `in_valid && in_ready`:
  - Normal sample (`wr_idx != N_POINTS-1` and `in_last = 0`): store `in_sample` at `bank[wr_bank][wr_idx]`, then `wr_idx++`.
  - Final sample (`wr_idx == N_POINTS-1`): store it, set `full[wr_bank]`, toggle `wr_bank`, and wrap `wr_idx` to 0. `in_last` is not required at this index; its value is ignored.
  - Early last (`in_last = 1` and `wr_idx != N_POINTS-1`): discard the sample and the partial frame, set `wr_idx` to 0, leave `wr_bank` unchanged, and pulse `err_abort` for 1 cycle. Stale data left in the bank is overwritten by the next frame.
- `frame_valid = full[rd_bank]`.
- `frame_out` = contents of `bank[rd_bank]`, packed with sample i at bits [16*i+15 -: 16].
- Pop occurs when `frame_valid && frame_ready`: clear `full[rd_bank]` and toggle `rd_bank`.
- A pop and a bank-completing accept may occur in the same cycle. They always act on different banks, and both updates apply.
- While `frame_valid` is high and no pop occurs, `frame_out` must not change.

## Timing
- Reset values:
  - `in_ready` = 1, `frame_valid` = 0, `err_abort` = 0, `wr_idx` = 0.
  - `wr_bank` = 0, `rd_bank` = 0, `full` = 00.
  - All bank storage cleared, so `frame_out` = 0.
- `rst` overrides everything, including mid-frame and mid-handshake. Any partial or held frames are lost.
- Latency: if the 64th sample is accepted at edge k, `frame_valid` is high in the cycle following edge k.
- Throughput: 1 sample/cycle sustained when the consumer pops each frame within 64 cycles of `frame_valid` rising.
- Both banks full: `in_ready` = 0. After a pop at edge p, `in_ready` returns to 1 in the cycle following p. There is no same-cycle pass-through.
- `err_abort` rises in the cycle after the offending accept and lasts exactly 1 cycle.
- `wr_idx` wraps 63 -> 0 only on a completed or aborted frame.
- Samples presented while `in_ready` = 0 are not consumed. The sender must hold them.

## Test plan
- Reset, then stream samples 0..63 with `frame_ready` = 1:
  - `frame_valid` rises 1 cycle after sample 63 is accepted.
  - `frame_out[16*i+15 -: 16]` = i for all i.
  - Pop occurs the same cycle; `frame_valid` is low the next cycle.
- Stream 3 back-to-back frames (values 0..191) with `frame_ready` = 0:
  - Two frames are accepted.
  - `in_ready` drops after sample 127.
  - `frame_out` holds frame 0 (0..63), stable for 20 idle cycles.
  - Raise `frame_ready` for 1 cycle: `frame_out` becomes 64..127 and `in_ready` = 1 the next cycle.
  - Sample 128 is accepted only after that.
- Send `in_last` with sample 10 of a frame:
  - `err_abort` pulses for 1 cycle, `wr_idx` = 0, `frame_valid` stays 0.
  - Then stream 64 samples of 0xA5A5: one frame where every lane = 0xA5A5.
- Pop the first frame in the same cycle the second frame's 64th sample is accepted:
  - `frame_valid` stays high.
  - `frame_out` switches from frame 0 to frame 1 data with no bubble.
  - `in_ready` stays 1.
- Assert `rst` after 30 samples of a frame, with one complete frame also held:
  - Next cycle: `frame_valid` = 0, `in_ready` = 1, `wr_idx` = 0, `frame_out` = 0.
  - A fresh 64-sample frame then loads correctly.
- Drive `in_valid` with a random 50% duty cycle and hold `in_sample` during gaps:
  - The frame contains exactly the accepted samples, in order.
  - Gaps do not advance `wr_idx`.
